toggle_monitor: RTL
===================

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameter EXP_HALF, default 25'd12_500_000: expected half-period of sig_in, in clk cycles.
REQ-002 Parameter TOL, default 25'd1_000: allowed deviation, in clk cycles.
REQ-003 Parameter LOCK_CNT, default 4: consecutive in-tolerance measurements required for lock.
REQ-004 Parameter TIMEOUT, default 2*EXP_HALF: number of edge-free cycles that declares loss of signal.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sig_in  input  1  asynchronous square wave under test, e.g. a blinking LED drive.
REQ-008 half_period  output  25  cycles between the last two detected edges.
REQ-009 half_valid  output  1  one-cycle strobe; half_period updated this cycle.
REQ-010 in_tol  output  1  last measurement within EXP_HALF±TOL.
REQ-011 locked  output  1  LOCK_CNT consecutive in-tolerance measurements seen.
REQ-012 no_signal  output  1  high while in SEEK state.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer, then a history flop; edge = sync2 XOR history, on either polarity.
REQ-014 All outputs SHALL be registered; half_valid SHALL rise 2 clk edges after the edge that first samples the new sig_in level.
REQ-015 A 25-bit counter cnt SHALL be 0 in the cycle after an edge and increment by 1 each cycle; measurement = cnt+1 at the edge.
REQ-016 cnt SHALL saturate at TIMEOUT-1 and never wrap.
REQ-017 FSM states: SEEK, TRACK, LOCK; reset state SEEK.
REQ-018 SEEK: first edge -> TRACK, cnt cleared, no half_valid strobe, good_cnt=0.
REQ-019 TRACK/LOCK: each edge -> half_period<=cnt+1, half_valid=1 for one cycle, in_tol<=(|cnt+1-EXP_HALF|<=TOL).
REQ-020 In-tol measurement SHALL increment good_cnt (saturating at LOCK_CNT); out-of-tol SHALL clear good_cnt.
REQ-021 TRACK -> LOCK on the strobe where good_cnt reaches LOCK_CNT; locked rises with that strobe.
REQ-022 LOCK -> TRACK on any out-of-tol strobe; locked falls with that strobe.
REQ-023 TRACK/LOCK -> SEEK when cnt reaches TIMEOUT-1 without an edge; locked<=0, in_tol<=0, good_cnt<=0; half_period SHALL be held.
REQ-024 Edge and timeout in the same cycle: edge SHALL win; measurement = TIMEOUT; no SEEK transition.
REQ-025 Difference arithmetic SHALL be unsigned, computed as larger minus smaller, with no overflow at 25 bits.

Reset
REQ-026 Asserting rst_n low SHALL immediately set: synchronizer and history flops=1, cnt=0, good_cnt=0, state=SEEK, half_period=0, half_valid=0, in_tol=0, locked=0, no_signal=1.
REQ-027 A spurious edge after reset release (sig_in=0) SHALL only arm TRACK; no strobe.
REQ-028 Reset mid-measurement SHALL discard the partial count; the first post-reset edge SHALL be treated per REQ-018.

Structure
REQ-029 Package toggle_monitor_pkg SHALL hold the state encoding (SEEK=2'd0, TRACK=2'd1, LOCK=2'd2), the counter width of 25, and the default parameter values.
REQ-030 Sub-module sync_edge_det SHALL contain the synchronizer, history flop and edge output; the FSM, counter and compare logic SHALL live in toggle_monitor.

Verification
(Bench parameters: EXP_HALF=10, TOL=1, LOCK_CNT=3, TIMEOUT=20.)
REQ-031 Square wave with 10-cycle half-period -> first edge gives no strobe; strobes half_period=10, in_tol=1; locked=1 on the 3rd strobe.
REQ-032 While locked, a single 13-cycle half -> in_tol=0, locked=0, state TRACK; 3 more 10-cycle halves -> relock.
REQ-033 Halves of 9 and 11 -> in_tol=1; halves of 8 and 12 -> in_tol=0, good_cnt cleared.
REQ-034 sig_in held constant after lock -> no_signal=1 exactly 20 cycles after the last edge; locked=0; half_period held at 10.
REQ-035 Edge arriving on the timeout cycle -> half_period=20, in_tol=0, no_signal stays 0.
REQ-036 rst_n pulsed low mid-half while locked -> all outputs at reset values asynchronously; next edge produces no strobe.

Source files
------------

// File: rtl/toggle_monitor_pkg.sv
// Shared types, widths and default parameters for the toggle monitor.
package toggle_monitor_pkg;

  localparam int unsigned CNT_W = 25;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_EXP_HALF = 25'd12_500_000;
  localparam logic [CNT_W-1:0] DEF_TOL      = 25'd1_000;
  localparam int unsigned      DEF_LOCK_CNT = 4;

  // Registered status payload presented on the monitor interface.
  typedef struct packed {
    logic [CNT_W-1:0] half_period;
    logic             half_valid;
    logic             in_tol;
    logic             locked;
    logic             no_signal;
  } status_t;

  // Unsigned distance between two counts; larger minus smaller never underflows.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/toggle_monitor_if.sv
// Signal-under-test and measurement status bundle.
interface toggle_monitor_if;
  import toggle_monitor_pkg::*;

  logic             sig_in;
  logic [CNT_W-1:0] half_period;
  logic             half_valid;
  logic             in_tol;
  logic             locked;
  logic             no_signal;

  modport master (
    output sig_in,
    input  half_period, half_valid, in_tol, locked, no_signal
  );

  modport slave (
    input  sig_in,
    output half_period, half_valid, in_tol, locked, no_signal
  );
endinterface

// File: rtl/toggle_monitor_sync_edge_det.sv
// Two-flop synchronizer plus history flop; flags either edge of the input.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_edge_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // Resetting to 1 makes a low input at release look like one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_edge_c = r_sync2 ^ r_hist;

endmodule

// File: rtl/toggle_monitor.sv
// Measures half-periods of a slow square wave and tracks lock/loss of signal.
module toggle_monitor
  import toggle_monitor_pkg::*;
#(
  parameter logic [CNT_W-1:0] EXP_HALF = DEF_EXP_HALF,
  parameter logic [CNT_W-1:0] TOL      = DEF_TOL,
  parameter int unsigned      LOCK_CNT = DEF_LOCK_CNT,
  parameter logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2 * EXP_HALF)
) (
  input  logic               clk,
  input  logic               rst_n,
  toggle_monitor_if.slave    bus
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  localparam status_t RST_STATUS = '{
    half_period: '0,
    half_valid:  1'b0,
    in_tol:      1'b0,
    locked:      1'b0,
    no_signal:   1'b1
  };

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [GOOD_W-1:0] w_good_next;
  logic [GOOD_W-1:0] w_good_sat;
  status_t           r_status;

  logic              w_edge;
  logic [CNT_W-1:0]  w_meas;
  logic              w_meas_ok;
  logic              w_timeout;
  logic              w_strobe;
  logic              w_clr_cnt;
  logic              w_to_seek;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sig    (bus.sig_in),
    .o_edge_c (w_edge)
  );

  // Measurement and tolerance window; cnt never exceeds TIMEOUT-1 so +1 cannot wrap.
  assign w_meas     = r_cnt + CNT_W'(1);
  assign w_meas_ok  = (abs_diff(w_meas, EXP_HALF) <= TOL);
  assign w_timeout  = (r_cnt == TIMEOUT - CNT_W'(1));
  assign w_good_sat = (r_good_cnt == GOOD_W'(LOCK_CNT)) ? r_good_cnt
                                                        : r_good_cnt + GOOD_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SEEK;
    else        r_state <= w_next_state;
  end

  // Next-state and per-cycle control; an edge always takes priority over timeout.
  always_comb begin
    w_next_state = r_state;
    w_strobe     = 1'b0;
    w_clr_cnt    = 1'b0;
    w_to_seek    = 1'b0;
    w_good_next  = r_good_cnt;
    unique case (r_state)
      SEEK: begin
        if (w_edge) begin
          w_next_state = TRACK;
          w_clr_cnt    = 1'b1;
          w_good_next  = '0;
        end
      end
      TRACK, LOCK: begin
        if (w_edge) begin
          w_strobe  = 1'b1;
          w_clr_cnt = 1'b1;
          if (w_meas_ok) begin
            w_good_next = w_good_sat;
            if (w_good_sat == GOOD_W'(LOCK_CNT)) w_next_state = LOCK;
          end else begin
            w_good_next  = '0;
            w_next_state = TRACK;
          end
        end else if (w_timeout) begin
          w_next_state = SEEK;
          w_to_seek    = 1'b1;
          w_good_next  = '0;
        end
      end
      default: begin
        w_next_state = SEEK;
        w_good_next  = '0;
      end
    endcase
  end

  // Edge-to-edge counter, saturating at TIMEOUT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cnt <= '0;
    else if (w_clr_cnt)  r_cnt <= '0;
    else if (!w_timeout) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Consecutive in-tolerance measurement count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_good_cnt <= '0;
    else        r_good_cnt <= w_good_next;
  end

  // Registered status outputs; half_period is held across loss of signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= RST_STATUS;
    end else begin
      r_status.half_valid <= w_strobe;
      if (w_strobe) begin
        r_status.half_period <= w_meas;
        r_status.in_tol      <= w_meas_ok;
      end else if (w_to_seek) begin
        r_status.in_tol <= 1'b0;
      end
      r_status.locked    <= (w_next_state == LOCK);
      r_status.no_signal <= (w_next_state == SEEK);
    end
  end

  assign bus.half_period = r_status.half_period;
  assign bus.half_valid  = r_status.half_valid;
  assign bus.in_tol      = r_status.in_tol;
  assign bus.locked      = r_status.locked;
  assign bus.no_signal   = r_status.no_signal;

endmodule
